rs_issue_scheduler: RTL and testbench
=====================================

// Module: rs_issue_scheduler
// PURPOSE
//  Wakeup/select/issue controller for the 64-entry reservation station. Tracks per-slot
//  operand readiness and FU assignment, wakes slots on CDB tag broadcasts, and picks one
//  ready slot per FU (3 FUs) round-robin. Hands slot indices to the FUs over a
//  valid/ready handshake, then returns freed slots to the RS allocator.
// PARAMETERS
//  RS_SIZE  64  number of RS slots (power of 2)
//  IDX_W    6   slot index width, log2(RS_SIZE)
//  TAG_W    6   physical register tag width
//  FU count fixed at 3 (FU ids 0..2; id 3 illegal)
// PORTS
//  clk            in   1        clock, rising edge
//  reset          in   1        asynchronous, active-high
//  flush          in   1        sync clear of all slots (mispredict)
//  alloc_valid    in   1        RS wrote a new entry this cycle
//  alloc_idx      in   IDX_W    slot written
//  alloc_fu       in   2        FU assigned to the entry
//  alloc_rs1_tag  in   TAG_W    rs1 physical tag
//  alloc_rs2_tag  in   TAG_W    rs2 physical tag
//  alloc_rs1_rdy  in   1        rs1 value already valid
//  alloc_rs2_rdy  in   1        rs2 value already valid
//  cdb_valid      in   3        per-lane broadcast valid
//  cdb_tag        in   3*TAG_W  lane n at [n*TAG_W +: TAG_W]
//  fu_ready       in   3        FU n accepts an issue this cycle
//  issue_valid    out  3        slot offered to FU n
//  issue_idx      out  3*IDX_W  slot offered to FU n
//  free_valid     out  3        slot released (handshake done) for FU n
//  free_idx       out  3*IDX_W  released slot
//  occupancy      out  IDX_W+1  live slots (allocated, not yet freed)
//  full           out  1        occupancy == RS_SIZE
//  alloc_err      out  1        sticky: alloc to live slot or alloc_fu==3
// BEHAVIOUR
//  Slot state: live, issued, fu[1:0], tag1/2, rdy1/2. Everything is reset by reset
//   and flush; all outputs reset to 0.
//  Alloc: on alloc_valid, the slot becomes live with issued=0 at the next edge. If a
//   CDB lane in the same cycle matches a not-ready alloc tag, that rdy bit is set
//   (bypass). Alloc to a live slot or with alloc_fu==3 is dropped and sets alloc_err.
//  Wakeup: for every live slot, rdyK is set at the edge when any cdb_valid[n] lane has
//   cdb_tag[n]==tagK. The slot is eligible the cycle after the wakeup edge.
//  Eligible = live & !issued & rdy1 & rdy2 & fu==n.
//  Select: per FU n with no offer outstanding (issue_valid[n]==0, or the offer
//   completes this cycle), choose the first eligible slot scanning up from ptr[n]
//   modulo RS_SIZE. The choice is registered: issue_valid/issue_idx go high on the
//   next edge and the slot's issued bit is set. Minimum latency from
//   alloc(both ready) to issue_valid is 2 edges.
//  Handshake: transfer occurs when issue_valid[n] & fu_ready[n]. issue_idx is held
//   stable while issue_valid is high and not accepted. On transfer:
//   - free_valid[n]/free_idx[n] pulse for one cycle on the next edge;
//   - the slot is cleared;
//   - ptr[n] = issue_idx+1 (wraps 63 -> 0).
//   Back-to-back issue to the same FU is allowed: the select for the next offer runs
//   in the transfer cycle.
//  occupancy: next = occ + accepted alloc - transfers this cycle (0..3).
//   full blocks nothing internally; the RS must not alloc when full.
//  Alloc to a slot being freed this cycle is an error (the slot is still live).
//  Flush: same-cycle alloc/transfer are ignored; all state -> 0 next edge; ptrs -> 0.
//  Reset mid-handshake: the offer is dropped, no free pulse.
// CONFIGURATION
//  RS_SCHED_STATS_EN defined: adds ports stall_cnt out 3*32 (per-FU cycles with
//   issue_valid & !fu_ready) and issue_cnt out 3*32 (per-FU transfers). Counters are
//   saturating, cleared by reset only (not flush).
//  RS_SCHED_STATS_EN undefined: ports and counters are absent; behaviour is otherwise
//   identical.
// TESTING
//  1. alloc idx 0, fu 1, both rdy, fu_ready=3'b111 -> issue_valid=3'b010, idx1=0 two
//     edges later; free_valid[1], free_idx=0 next cycle; occupancy 1->0.
//  2. alloc idx 5, fu 0, rs1 tag 12 not rdy; cdb_valid=001, tag 12 three cycles later
//     -> issue_valid[0] with idx 5 exactly 2 edges after the CDB edge; no earlier offer.
//  3. Slots 3,7,60 ready on fu 2, fu_ready[2]=1 -> issue order 3,7,60; add slot 1 after
//     60 issues -> wraps and issues 1.
//  4. fu_ready[0]=0 for 4 cycles with slot 9 offered -> issue_idx0 stays 9 and
//     free_valid stays 0; accept on cycle 5 -> free_idx0=9 (stats: stall_cnt0=4).
//  5. alloc idx 2 while live -> alloc_err=1, occupancy unchanged; alloc_fu=3 -> alloc_err.
//  6. flush with 10 live slots and 3 offers pending -> next cycle issue_valid=0,
//     occupancy=0, no free pulses.

Source files
------------

// File: rtl/rs_issue_scheduler.sv
// Reservation-station wakeup/select/issue controller: 3 FUs, round-robin select per FU.
// Optional per-FU stall/issue counters when RS_SCHED_STATS_EN is defined.

module rs_sel_lane #(
   parameter int RS_SIZE = 64,
   parameter int IDX_W   = 6
) (
   input  logic [RS_SIZE-1:0] elig,
   input  logic [IDX_W-1:0]   start,
   output logic               found,
   output logic [IDX_W-1:0]   idx
);
   logic [IDX_W-1:0] j;

   // First eligible slot at or after start, wrapping through the index width.
   always_comb begin
      found = 1'b0;
      idx   = start;
      j     = '0;
      for (int i = 0; i < RS_SIZE; i++) begin
         j = start + IDX_W'(i);
         if (!found && elig[j]) begin
            found = 1'b1;
            idx   = j;
         end
      end
   end
endmodule

module rs_issue_scheduler #(
   parameter int RS_SIZE = 64,
   parameter int IDX_W   = 6,
   parameter int TAG_W   = 6
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush,
   input  logic                 alloc_valid,
   input  logic [IDX_W-1:0]     alloc_idx,
   input  logic [1:0]           alloc_fu,
   input  logic [TAG_W-1:0]     alloc_rs1_tag,
   input  logic [TAG_W-1:0]     alloc_rs2_tag,
   input  logic                 alloc_rs1_rdy,
   input  logic                 alloc_rs2_rdy,
   input  logic [2:0]           cdb_valid,
   input  logic [3*TAG_W-1:0]   cdb_tag,
   input  logic [2:0]           fu_ready,
   output logic [2:0]           issue_valid,
   output logic [3*IDX_W-1:0]   issue_idx,
   output logic [2:0]           free_valid,
   output logic [3*IDX_W-1:0]   free_idx,
   output logic [IDX_W:0]       occupancy,
   output logic                 full,
   output logic                 alloc_err
`ifdef RS_SCHED_STATS_EN
   ,
   output logic [3*32-1:0]      stall_cnt,
   output logic [3*32-1:0]      issue_cnt
`endif
);
   typedef struct packed {
      logic             live;
      logic             issued;
      logic [1:0]       fu;
      logic [TAG_W-1:0] tag1;
      logic [TAG_W-1:0] tag2;
      logic             rdy1;
      logic             rdy2;
   } slot_t;

   slot_t slots    [RS_SIZE];
   slot_t slot_nxt [RS_SIZE];

   logic [2:0][IDX_W-1:0]   iss_idx, fr_idx, ptr, start, sel_idx;
   logic [2:0][RS_SIZE-1:0] elig;
   logic [2:0]              sel_found, take, xfer;
   logic                    acc, bad;
   logic [IDX_W:0]          occ_nxt;

   function automatic logic cdb_hit(input logic [2:0] v, input logic [3*TAG_W-1:0] tg,
                                    input logic [TAG_W-1:0] t);
      logic h = 1'b0;
      for (int n = 0; n < 3; n++)
         if (v[n] && tg[n*TAG_W +: TAG_W] == t) h = 1'b1;
      return h;
   endfunction

   assign issue_idx = iss_idx;
   assign free_idx  = fr_idx;
   assign full      = (occupancy == (IDX_W+1)'(RS_SIZE));
   assign xfer      = issue_valid & fu_ready;
   assign bad       = alloc_valid & (slots[alloc_idx].live | (alloc_fu == 2'd3));
   assign acc       = alloc_valid & ~bad;
   assign occ_nxt   = occupancy + (IDX_W+1)'(acc) - (IDX_W+1)'(xfer[0])
                      - (IDX_W+1)'(xfer[1]) - (IDX_W+1)'(xfer[2]);

   for (genvar n = 0; n < 3; n++) begin : g_fu
      for (genvar i = 0; i < RS_SIZE; i++) begin : g_elig
         assign elig[n][i] = slots[i].live & ~slots[i].issued & slots[i].rdy1 &
                             slots[i].rdy2 & (slots[i].fu == 2'(n));
      end
      // On a transfer the next scan already starts past the slot being handed over.
      assign start[n] = xfer[n] ? iss_idx[n] + IDX_W'(1) : ptr[n];
      assign take[n]  = sel_found[n] & (~issue_valid[n] | fu_ready[n]) & ~flush;

      rs_sel_lane #(.RS_SIZE(RS_SIZE), .IDX_W(IDX_W)) u_sel (
         .elig  (elig[n]),
         .start (start[n]),
         .found (sel_found[n]),
         .idx   (sel_idx[n])
      );
   end

   always_comb begin
      for (int i = 0; i < RS_SIZE; i++) begin
         slot_nxt[i] = slots[i];
         if (slots[i].live) begin
            if (cdb_hit(cdb_valid, cdb_tag, slots[i].tag1)) slot_nxt[i].rdy1 = 1'b1;
            if (cdb_hit(cdb_valid, cdb_tag, slots[i].tag2)) slot_nxt[i].rdy2 = 1'b1;
         end
      end
      for (int n = 0; n < 3; n++)
         if (take[n]) slot_nxt[sel_idx[n]].issued = 1'b1;
      for (int n = 0; n < 3; n++)
         if (xfer[n]) slot_nxt[iss_idx[n]] = '0;
      if (acc) begin
         slot_nxt[alloc_idx].live   = 1'b1;
         slot_nxt[alloc_idx].issued = 1'b0;
         slot_nxt[alloc_idx].fu     = alloc_fu;
         slot_nxt[alloc_idx].tag1   = alloc_rs1_tag;
         slot_nxt[alloc_idx].tag2   = alloc_rs2_tag;
         slot_nxt[alloc_idx].rdy1   = alloc_rs1_rdy | cdb_hit(cdb_valid, cdb_tag, alloc_rs1_tag);
         slot_nxt[alloc_idx].rdy2   = alloc_rs2_rdy | cdb_hit(cdb_valid, cdb_tag, alloc_rs2_tag);
      end
      if (flush)
         for (int i = 0; i < RS_SIZE; i++) slot_nxt[i] = '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < RS_SIZE; i++) slots[i] <= '0;
      end else begin
         for (int i = 0; i < RS_SIZE; i++) slots[i] <= slot_nxt[i];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         issue_valid <= '0;
         iss_idx     <= '0;
         free_valid  <= '0;
         fr_idx      <= '0;
         ptr         <= '0;
         occupancy   <= '0;
         alloc_err   <= 1'b0;
      end else if (flush) begin
         issue_valid <= '0;
         iss_idx     <= '0;
         free_valid  <= '0;
         fr_idx      <= '0;
         ptr         <= '0;
         occupancy   <= '0;
         alloc_err   <= 1'b0;
      end else begin
         free_valid <= xfer;
         occupancy  <= occ_nxt;
         if (bad) alloc_err <= 1'b1;
         for (int n = 0; n < 3; n++) begin
            if (xfer[n]) begin
               fr_idx[n] <= iss_idx[n];
               ptr[n]    <= iss_idx[n] + IDX_W'(1);
            end
            // An offer is held stable until accepted.
            if (!issue_valid[n] || fu_ready[n]) begin
               issue_valid[n] <= sel_found[n];
               if (sel_found[n]) iss_idx[n] <= sel_idx[n];
            end
         end
      end
   end

`ifdef RS_SCHED_STATS_EN
   logic [2:0][31:0] stl, isc;
   assign stall_cnt = stl;
   assign issue_cnt = isc;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stl <= '0;
         isc <= '0;
      end else begin
         for (int n = 0; n < 3; n++) begin
            if (issue_valid[n] && !fu_ready[n] && stl[n] != '1) stl[n] <= stl[n] + 32'd1;
            if (xfer[n] && !flush && isc[n] != '1) isc[n] <= isc[n] + 32'd1;
         end
      end
   end
`endif
endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Directed-vector bench for rs_issue_scheduler: latency, wakeup, round-robin wrap,
// backpressure, alloc errors, flush, full and reset-mid-handshake.
module tb_rs_issue_scheduler;
   localparam int IDX_W = 6;
   localparam int TAG_W = 6;

   logic               clk = 1'b0;
   logic               reset, flush, alloc_valid;
   logic [IDX_W-1:0]   alloc_idx;
   logic [1:0]         alloc_fu;
   logic [TAG_W-1:0]   alloc_rs1_tag, alloc_rs2_tag;
   logic               alloc_rs1_rdy, alloc_rs2_rdy;
   logic [2:0]         cdb_valid, fu_ready;
   logic [3*TAG_W-1:0] cdb_tag;
   logic [2:0]         issue_valid, free_valid;
   logic [3*IDX_W-1:0] issue_idx, free_idx;
   logic [IDX_W:0]     occupancy;
   logic               full, alloc_err;
`ifdef RS_SCHED_STATS_EN
   logic [95:0]        stall_cnt, issue_cnt;
`endif

   rs_issue_scheduler dut (
      .clk(clk), .reset(reset), .flush(flush), .alloc_valid(alloc_valid),
      .alloc_idx(alloc_idx), .alloc_fu(alloc_fu), .alloc_rs1_tag(alloc_rs1_tag),
      .alloc_rs2_tag(alloc_rs2_tag), .alloc_rs1_rdy(alloc_rs1_rdy),
      .alloc_rs2_rdy(alloc_rs2_rdy), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
      .fu_ready(fu_ready), .issue_valid(issue_valid), .issue_idx(issue_idx),
      .free_valid(free_valid), .free_idx(free_idx), .occupancy(occupancy),
      .full(full), .alloc_err(alloc_err)
`ifdef RS_SCHED_STATS_EN
      , .stall_cnt(stall_cnt), .issue_cnt(issue_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [IDX_W-1:0] iidx(input int n);
      return issue_idx[n*IDX_W +: IDX_W];
   endfunction

   function automatic logic [IDX_W-1:0] fidx(input int n);
      return free_idx[n*IDX_W +: IDX_W];
   endfunction

   task automatic do_alloc(input int idx, input int fu, input int t1, input int t2,
                           input bit r1, input bit r2);
      alloc_valid   = 1'b1;
      alloc_idx     = IDX_W'(idx);
      alloc_fu      = 2'(fu);
      alloc_rs1_tag = TAG_W'(t1);
      alloc_rs2_tag = TAG_W'(t2);
      alloc_rs1_rdy = r1;
      alloc_rs2_rdy = r2;
      step;
      alloc_valid   = 1'b0;
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; alloc_valid = 1'b0; alloc_idx = '0; alloc_fu = '0;
      alloc_rs1_tag = '0; alloc_rs2_tag = '0; alloc_rs1_rdy = 1'b0; alloc_rs2_rdy = 1'b0;
      cdb_valid = '0; cdb_tag = '0; fu_ready = 3'b111;
      step; step;
      chk("rst_iv", issue_valid, 0);
      chk("rst_fv", free_valid, 0);
      chk("rst_occ", occupancy, 0);
      chk("rst_full", full, 0);
      chk("rst_err", alloc_err, 0);
      reset = 1'b0;
      step;

      // 1: ready-at-alloc latency and free pulse
      do_alloc(0, 1, 0, 0, 1, 1);
      chk("t1_occ1", occupancy, 1);
      chk("t1_iv_early", issue_valid, 0);
      step;
      chk("t1_iv", issue_valid, 3'b010);
      chk("t1_idx", iidx(1), 0);
      step;
      chk("t1_fv", free_valid, 3'b010);
      chk("t1_fidx", fidx(1), 0);
      chk("t1_occ0", occupancy, 0);
      chk("t1_iv_done", issue_valid, 0);
      step;
      chk("t1_fv_pulse", free_valid, 0);

      // 2: CDB wakeup
      do_alloc(5, 0, 12, 0, 0, 1);
      chk("t2_occ", occupancy, 1);
      step; chk("t2_wait_a", issue_valid, 0);
      step; chk("t2_wait_b", issue_valid, 0);
      cdb_valid = 3'b001; cdb_tag = 18'd12;
      step;
      cdb_valid = 3'b000;
      chk("t2_pre", issue_valid, 0);
      step;
      chk("t2_iv", issue_valid, 3'b001);
      chk("t2_idx", iidx(0), 5);
      step;
      chk("t2_fv", free_valid, 3'b001);
      chk("t2_fidx", fidx(0), 5);
      chk("t2_occ0", occupancy, 0);

      // 3: round-robin order and wrap on FU 2
      fu_ready = 3'b011;
      do_alloc(3, 2, 0, 0, 1, 1);
      do_alloc(7, 2, 0, 0, 1, 1);
      do_alloc(60, 2, 0, 0, 1, 1);
      chk("t3_occ", occupancy, 3);
      chk("t3_iv_held", issue_valid, 3'b100);
      chk("t3_first", iidx(2), 3);
      fu_ready = 3'b111;
      step;
      chk("t3_free3", fidx(2), 3);
      chk("t3_fv3", free_valid, 3'b100);
      chk("t3_second", iidx(2), 7);
      step;
      chk("t3_free7", fidx(2), 7);
      chk("t3_third", iidx(2), 60);
      do_alloc(1, 2, 0, 0, 1, 1);
      chk("t3_free60", fidx(2), 60);
      chk("t3_gap", issue_valid, 0);
      step;
      chk("t3_wrap_iv", issue_valid, 3'b100);
      chk("t3_wrap_idx", iidx(2), 1);
      step;
      chk("t3_free1", fidx(2), 1);
      chk("t3_occ0", occupancy, 0);
`ifdef RS_SCHED_STATS_EN
      chk("t3_issue_cnt2", issue_cnt[64 +: 32], 4);
`endif

      // 4: backpressure on FU 0
      fu_ready = 3'b110;
      do_alloc(9, 0, 0, 0, 1, 1);
      step;
      for (int k = 0; k < 4; k++) begin
         chk("t4_hold_iv", issue_valid[0], 1);
         chk("t4_hold_idx", iidx(0), 9);
         chk("t4_hold_fv", free_valid, 0);
         step;
      end
      fu_ready = 3'b111;
      step;
      chk("t4_fv", free_valid, 3'b001);
      chk("t4_fidx", fidx(0), 9);
`ifdef RS_SCHED_STATS_EN
      chk("t4_stall_cnt0", stall_cnt[31:0], 4);
`endif

      // 5: alloc to a live slot
      fu_ready = 3'b000;
      do_alloc(2, 0, 0, 0, 1, 1);
      chk("t5_err0", alloc_err, 0);
      do_alloc(2, 1, 0, 0, 1, 1);
      chk("t5_err_live", alloc_err, 1);
      chk("t5_occ", occupancy, 1);

      // 6: flush with 10 live slots and 3 pending offers
      for (int i = 0; i < 9; i++) do_alloc(10 + i, i % 3, 0, 0, 1, 1);
      chk("t6_occ10", occupancy, 10);
      step;
      chk("t6_iv_all", issue_valid, 3'b111);
      flush = 1'b1; fu_ready = 3'b111;
      alloc_valid = 1'b1; alloc_idx = 6'd30; alloc_fu = 2'd0;
      step;
      flush = 1'b0; alloc_valid = 1'b0;
      chk("t6_iv", issue_valid, 0);
      chk("t6_occ", occupancy, 0);
      chk("t6_fv", free_valid, 0);
      chk("t6_err_clr", alloc_err, 0);
      step;
      chk("t6_fv_after", free_valid, 0);
      chk("t6_iv_after", issue_valid, 0);

      // 5b: illegal FU id
      do_alloc(4, 3, 0, 0, 1, 1);
      chk("t5_err_fu3", alloc_err, 1);
      chk("t5_occ_fu3", occupancy, 0);
      step;
      chk("t5_iv_fu3", issue_valid, 0);

      // full boundary
      flush = 1'b1; step; flush = 1'b0;
      fu_ready = 3'b000;
      for (int i = 0; i < 64; i++) do_alloc(i, 0, 0, 0, 1, 1);
      chk("full_occ", occupancy, 64);
      chk("full", full, 1);
      step;
      chk("full_iv", issue_valid, 3'b001);

      // reset during an open offer
      fu_ready = 3'b111;
      reset = 1'b1;
      #1;
      chk("rstmid_iv", issue_valid, 0);
      chk("rstmid_occ", occupancy, 0);
      chk("rstmid_full", full, 0);
      step;
      chk("rstmid_fv", free_valid, 0);
      reset = 1'b0;
      step;
      chk("rstmid_fv2", free_valid, 0);
      chk("rstmid_iv2", issue_valid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
